// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the execute stage.
// Multiplies finish MUL_CYCLES edges after accept. Divides use restoring division and finish 34 edges after accept.
module muldiv_unit #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        nullify,
    input  logic        stall,
    input  logic        bubble,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] dest_hi,
    output logic [31:0] dest_lo
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 2);
    localparam logic [4:0] DIV_LAST = 5'd31;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nx;

    logic        accept;
    logic        op_is_div;
    logic        op_signed;
    logic        load_result;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    logic [2:0]  op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [63:0] acc_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;

    logic        sgn_q;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_p;
    logic [63:0] mul_res;

    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] div_res;

    assign accept       = start & ~bubble & ~nullify & (state == IDLE);
    assign busy         = accept | (state == MUL) | (state == DIV) | (state == FIX);
    assign result_valid = (state == DONE);

    assign op_is_div = (op[2:1] == 2'b01);
    assign op_signed = ~op[0];
    assign rs_mag    = (op_signed & rs[31]) ? -rs : rs;
    assign rt_mag    = (op_signed & rt[31]) ? -rt : rt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // nullify overrides both accept and completion on the same edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        if (nullify) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nx = op_is_div ? DIV : MUL;
                        cnt_nx   = '0;
                    end
                end
                MUL: begin
                    if (cnt == MUL_LAST) begin
                        state_nx = DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
                DIV: begin
                    if (cnt == DIV_LAST) begin
                        state_nx = FIX;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
                FIX:     state_nx = DONE;
                DONE:    if (!stall) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign load_result = (state_nx == DONE) && (state != DONE);

    // Extending both operands to 64 bits makes the low 64 product bits correct for signed and unsigned alike.
    always_comb begin
        sgn_q = ~op_q[0];
        mul_a = {{32{sgn_q & rs_q[31]}}, rs_q};
        mul_b = {{32{sgn_q & rt_q[31]}}, rt_q};
        mul_p = mul_a * mul_b;
        if (!op_q[2]) begin
            mul_res = mul_p;
        end else if (op_q[1]) begin
            mul_res = acc_q - mul_p;
        end else begin
            mul_res = acc_q + mul_p;
        end
    end

    always_comb begin
        div_shift = {rem_q, quo_q[31]};
        div_diff  = div_shift - {1'b0, dvsr_q};
        div_ge    = ~div_diff[32];
        neg_q     = ~op_q[0] & (rs_q[31] ^ rt_q[31]);
        neg_r     = ~op_q[0] & rs_q[31];
        if (rt_q == 32'd0) begin
            div_res = {rs_q, 32'hFFFF_FFFF};
        end else begin
            div_res = {(neg_r ? -rem_q : rem_q), (neg_q ? -quo_q : quo_q)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath is reset as well, so a reset mid-operation leaves no partial result behind.
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            dest_hi <= '0;
            dest_lo <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                rs_q   <= rs;
                rt_q   <= rt;
                acc_q  <= {hi_in, lo_in};
                quo_q  <= rs_mag;
                rem_q  <= '0;
                dvsr_q <= rt_mag;
            end else if (state == DIV) begin
                quo_q <= {quo_q[30:0], div_ge};
                rem_q <= div_ge ? div_diff[31:0] : div_shift[31:0];
            end
            if (load_result) begin
                {dest_hi, dest_lo} <= (state == FIX) ? div_res : mul_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases followed by random operations.
// Each result is checked against an arithmetic reference model for value and latency.
module tb_muldiv_unit;

    localparam int MC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [31:0] hi_in = '0;
    logic [31:0] lo_in = '0;
    logic        nullify = 1'b0;
    logic        stall = 1'b0;
    logic        bubble = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] dest_hi;
    logic [31:0] dest_lo;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tid = 0;

    typedef struct {
        logic [63:0] val;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic rv_prev = 1'b0;

    muldiv_unit #(.MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .hi_in        (hi_in),
        .lo_in        (lo_in),
        .nullify      (nullify),
        .stall        (stall),
        .bubble       (bubble),
        .busy         (busy),
        .result_valid (result_valid),
        .dest_hi      (dest_hi),
        .dest_lo      (dest_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // HI:LO reference computed directly from the instruction definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint      sa;
        longint      sbv;
        logic [63:0] prod;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        acc = {h, l};
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 3'd2) return {32'(sa % sbv), 32'(sa / sbv)};
            return {a % b, a / b};
        end
        if (o == 3'd0 || o == 3'd4 || o == 3'd6) prod = 64'(sa * sbv);
        else prod = {32'd0, a} * {32'd0, b};
        if (o == 3'd4 || o == 3'd5) return acc + prod;
        if (o == 3'd6 || o == 3'd7) return acc - prod;
        return prod;
    endfunction

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every rising result_valid must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (result_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(result_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(dest_hi), 64'(e.val[63:32]));
                check({e.name, "_lo"}, 64'(dest_lo), 64'(e.val[31:0]));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
        rv_prev = result_valid;
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input int nbub,
                         input bit expect_res, output logic [63:0] e);
        exp_t x;
        int   lat;
        op = o; rs = a; rt = b; hi_in = h; lo_in = l;
        start = 1'b1;
        nullify = 1'b0;
        e = model(o, a, b, h, l);
        for (int i = 0; i < nbub; i++) begin
            bubble = 1'b1;
            @(negedge clk);
            check("busy_bubbled", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end
        bubble = 1'b0;
        @(negedge clk);
        check("busy_accept", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        tid++;
        lat = (o == 3'd2 || o == 3'd3) ? 33 : MC - 1;
        if (expect_res) begin
            x.val  = e;
            x.due  = cyc + lat;
            x.name = $sformatf("t%0d_op%0d", tid, o);
            sb.push_back(x);
        end
    endtask

    // Returns at the negedge where result_valid is first seen high.
    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 40) begin
            check("busy_inflight", 64'(busy), 64'd1);
            n++;
            @(negedge clk);
        end
        check("done_seen", 64'(result_valid), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
    endtask

    // Holds stall for nstall cycles in DONE, then lets DONE exit; optionally raises the next start during the exit cycle.
    task automatic release_done(input int nstall, input logic [63:0] e, input bit b2b,
                                input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l);
        stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("valid_stalled", 64'(result_valid), 64'd1);
            check("dest_stalled", {dest_hi, dest_lo}, e);
        end
        stall = 1'b0;
        if (b2b) begin
            op = o; rs = a; rt = b; hi_in = h; lo_in = l;
            start = 1'b1;
            #1;
            check("no_accept_from_done", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        check("valid_falls", 64'(result_valid), 64'd0);
        check("dest_hold", {dest_hi, dest_lo}, e);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, output logic [63:0] e);
        issue(o, a, b, h, l, 0, 1'b1, e);
        wait_done();
        release_done(0, e, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [63:0] e;
        logic [63:0] e_prev;
        logic [63:0] e_dummy;
        logic [2:0]  no;
        logic [31:0] na, nb, nh, nl;
        bit          b2b;
        int          rises;

        #12;
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(dest_hi), 64'd0);
        check("reset_lo", 64'(dest_lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, e);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, e);
        run_op(3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, e);
        run_op(3'd7, 32'd1, 32'd1, 32'd0, 32'd0, e);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, e);
        run_op(3'd3, 32'd7, 32'd0, 32'd0, 32'd0, e);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, e);

        // Start held under bubble for 3 cycles; latency counts from the first unbubbled edge.
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 3, 1'b1, e);
        wait_done();
        release_done(0, e, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // DIVU result held through a 5-cycle stall, then a back-to-back MULTU.
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1'b1, e);
        wait_done();
        release_done(5, e, 1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0000_0010, 32'd0, 32'd0);
        issue(3'd1, 32'hDEAD_BEEF, 32'h0000_0010, 32'd0, 32'd0, 0, 1'b1, e);
        wait_done();
        release_done(0, e, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        e_prev = e;

        // nullify at divide iteration 10 discards the operation.
        issue(3'd2, 32'h7654_3210, 32'd13, 32'd0, 32'd0, 0, 1'b0, e_dummy);
        repeat (9) @(posedge clk);
        #1;
        nullify = 1'b1;
        @(negedge clk);
        check("busy_during_nullify", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        nullify = 1'b0;
        check("nullify_idle_busy", 64'(busy), 64'd0);
        check("nullify_valid", 64'(result_valid), 64'd0);
        check("nullify_dest_kept", {dest_hi, dest_lo}, e_prev);
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) rises++;
        end
        check("nullify_no_result", 64'(rises), 64'd0);
        check("nullify_dest_still", {dest_hi, dest_lo}, e_prev);

        // nullify beats accept in IDLE.
        @(posedge clk);
        #1;
        start = 1'b1;
        nullify = 1'b1;
        op = 3'd0;
        #1;
        check("nullify_blocks_accept", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        nullify = 1'b0;

        // Random operations, random bubbles, stalls and back-to-back starts.
        no = 3'($urandom_range(0, 7));
        issue(no, rword(), rword(), rword(), rword(), 0, 1'b1, e);
        for (int k = 0; k < 30; k++) begin
            wait_done();
            no = 3'($urandom_range(0, 7));
            na = rword(); nb = rword(); nh = rword(); nl = rword();
            b2b = 1'($urandom_range(0, 1));
            release_done(int'($urandom_range(0, 3)), e, b2b, no, na, nb, nh, nl);
            issue(no, na, nb, nh, nl, int'($urandom_range(0, 2)), 1'b1, e);
        end
        wait_done();
        release_done(0, e, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Asynchronous reset during a multiply clears everything at once.
        issue(3'd0, 32'h0000_1234, 32'h0000_5678, 32'd0, 32'd0, 0, 1'b0, e_dummy);
        reset = 1'b0;
        #1;
        check("midreset_valid", 64'(result_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hi", 64'(dest_hi), 64'd0);
        check("midreset_lo", 64'(dest_lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd6, 32'd5, 32'd6, 32'd0, 32'd100, e);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
